eif_neuron_array: RTL and testbench
===================================

// Module: eif_neuron_array
// PURPOSE
//  N_CH-channel adaptive exponential integrate-and-fire neuron array, time-multiplexed over one datapath.
//  Each 'step' pulse advances every neuron by one time step: membrane update, spike and threshold adaptation.
//  Processes one channel per clock and publishes a spike vector with a 'done' strobe.
//  Sits between the stimulus/current source and downstream spike consumers.
// PARAMETERS
//  N_CH            4    number of neuron channels (>=1)
//  WIDTH           8    membrane/threshold/current width, unsigned
//  TH_INIT         100  threshold reset value
//  TH_MIN          32   adaptive threshold floor
//  TH_MAX          220  adaptive threshold ceiling (< 2^WIDTH)
//  V_T             80   exponential-term knee
//  EXP_SHIFT       5    exp term = (v-V_T)^2 >> EXP_SHIFT
//  LEAK_SHIFT      4    leak = v >> LEAK_SHIFT
//  ADAPT_INC_SHIFT 3    on spike: th += th >> ADAPT_INC_SHIFT
//  ADAPT_DEC_SHIFT 5    no spike: th -= th >> ADAPT_DEC_SHIFT
//  REFRAC_STEPS    2    refractory length in steps (REFRACTORY_EN only)
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous active-high reset
//  step       in   1           start one sweep; accepted only when busy=0
//  adapt_en   in   1           adaptive threshold enable; snapshotted at step accept
//  current    in   N_CH*WIDTH  per-channel input current; ch k = [k*WIDTH +: WIDTH]; snapshotted at step accept
//  busy       out  1           sweep in progress
//  done       out  1           one-cycle strobe: spikes valid and updated
//  spikes     out  N_CH        spike vector of the last completed sweep
//  rd_ch      in   $clog2(N_CH) (min 1)  debug read channel select
//  rd_state   out  WIDTH       membrane of rd_ch (combinational read)
//  rd_thresh  out  WIDTH       threshold of rd_ch (combinational read)
// BEHAVIOUR
//  Reset (rst=1 at clk edge): all v=0, all th=TH_INIT, spikes=0, done=0, busy=0, FSM=IDLE.
//   Aborts any sweep in progress; no done is issued for the aborted sweep.
//  FSM: IDLE --step--> RUN (snapshot current, adapt_en; ch=0; busy=1)
//   RUN: one channel per cycle, ch 0..N_CH-1; after ch=N_CH-1 -> DONE.
//   DONE (1 cycle): spikes <= shadow vector, done=1, busy=0 -> IDLE.
//  Latency: done is high in the cycle N_CH+1 edges after the accepting edge. Max step rate: one per N_CH+2 cycles.
//  step while busy=1 (RUN or DONE): ignored, not queued.
//  Per-channel update (intermediates 2*WIDTH+2 bits, no wrap):
//   exp  = (v > V_T) ? ((v-V_T)^2 >> EXP_SHIFT) : 0
//   sum  = v + I + exp - (v >> LEAK_SHIFT); clamp to 2^WIDTH-1
//   spike = (sum >= th): v <= 0, shadow[ch]=1; else v <= sum, shadow[ch]=0.
//  Threshold, only when adapt_en snapshot=1 (else th unchanged):
//   spike:    th <= min(th + (th>>ADAPT_INC_SHIFT), TH_MAX)
//   no spike: th <= max(th - (th>>ADAPT_DEC_SHIFT), TH_MIN)
//  Comparison uses th before this step's adaptation.
//  rd_state/rd_thresh read stored values; during RUN they may reflect old or new value per channel.
// CONFIGURATION
//  REFRACTORY_EN defined: per-channel counter, loaded with REFRAC_STEPS on spike.
//   While counter != 0: v held at 0, no spike, counter decrements by 1 per step.
//   Threshold decay still applies. Counter cleared by rst.
//  REFRACTORY_EN undefined: no counter logic. REFRAC_STEPS is ignored. Channel integrates on the step after a spike.
// TESTING
//  1. Reset then idle: spikes=0, done=0, busy=0; rd_thresh=100 for every ch.
//  2. ch0 I=30, others 0, adapt_en=0: ch0 v after steps 1-3 = 30, 59, 86.
//     Step 4: spikes=4'b0001, v0=0. Each done arrives exactly 5 cycles after the accepting edge.
//  3. adapt_en=1, ch1 I=255 from v=0: step 1 spikes[1]=1, th1=112. Idle ch2: th2=97, and repeated steps floor th2 at 32.
//     Repeated ch1 spikes ceiling th1 at 220 (no wrap).
//  4. Pulse step again 2 cycles after accept: ignored, single done.
//     Assert rst mid-RUN: no done, all v=0, th=100, busy=0 next cycle.
//  5. REFRACTORY_EN, ch0 I=255: spikes[0] pattern over 6 steps = 1,0,0,1,0,0.
//     Without REFRACTORY_EN: 1,1,1,1,1,1.
//  6. Saturation: v=99, th=220 (adapt off), I=255: sum clamps to 255, spike asserted, v=0.

Source files
------------

// File: rtl/eif_neuron_array.sv
// Time-multiplexed adaptive exponential integrate-and-fire neuron array: one channel per clock per sweep.
// Optional per-channel refractory counter is built when REFRACTORY_EN is defined.
module eif_neuron_array #(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned TH_INIT         = 100,
  parameter int unsigned TH_MIN          = 32,
  parameter int unsigned TH_MAX          = 220,
  parameter int unsigned V_T             = 80,
  parameter int unsigned EXP_SHIFT       = 5,
  parameter int unsigned LEAK_SHIFT      = 4,
  parameter int unsigned ADAPT_INC_SHIFT = 3,
  parameter int unsigned ADAPT_DEC_SHIFT = 5,
  parameter int unsigned REFRAC_STEPS    = 2,
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step,
  input  logic                   adapt_en,
  input  logic [N_CH*WIDTH-1:0]  current,
  output logic                   busy,
  output logic                   done,
  output logic [N_CH-1:0]        spikes,
  input  logic [CH_W-1:0]        rd_ch,
  output logic [WIDTH-1:0]       rd_state,
  output logic [WIDTH-1:0]       rd_thresh
);

  localparam int unsigned EW = 2*WIDTH + 2;
  localparam logic [EW-1:0] SAT    = EW'({WIDTH{1'b1}});
  localparam logic [EW-1:0] VT_E   = EW'(V_T);
  localparam logic [EW-1:0] TMAX_E = EW'(TH_MAX);
  localparam logic [EW-1:0] TMIN_E = EW'(TH_MIN);

  if (N_CH < 1 || 64'(TH_MAX) >= (64'd1 << WIDTH) || REFRAC_STEPS > 32'd65535) begin : g_bad_params
    $error("eif_neuron_array: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_ch;
  logic              r_adapt;
  logic [WIDTH-1:0]  r_cur [N_CH];
  logic [WIDTH-1:0]  r_v   [N_CH];
  logic [WIDTH-1:0]  r_th  [N_CH];
  logic [N_CH-1:0]   r_shadow;
  logic [N_CH-1:0]   r_spikes;
  logic              r_done;
  logic              r_busy;

  logic              w_accept;
  logic              w_proc;
  logic              w_publish;
  logic              w_last;

  logic [WIDTH-1:0]  w_v;
  logic [WIDTH-1:0]  w_i;
  logic [WIDTH-1:0]  w_th;
  logic [EW-1:0]     w_v_ext;
  logic [EW-1:0]     w_diff;
  logic [EW-1:0]     w_exp;
  logic [EW-1:0]     w_sum;
  logic [EW-1:0]     w_sum_sat;
  logic [EW-1:0]     w_th_up;
  logic [EW-1:0]     w_th_dn;
  logic [WIDTH-1:0]  w_th_new;
  logic [WIDTH-1:0]  w_v_new;
  logic              w_refr;
  logic              w_spike;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (step) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    w_accept  = 1'b0;
    w_proc    = 1'b0;
    w_publish = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      S_IDLE: w_accept = step;
      S_RUN: begin
        w_proc = 1'b1;
        w_last = (r_ch == CH_W'(N_CH - 1));
      end
      S_DONE:  w_publish = 1'b1;
      default: ;
    endcase
  end

`ifdef REFRACTORY_EN
  localparam int unsigned RW = (REFRAC_STEPS > 1) ? $clog2(REFRAC_STEPS + 1) : 1;
  logic [RW-1:0] r_rcnt [N_CH];

  assign w_refr = (r_rcnt[r_ch] != '0);

  // Refractory counters: loaded on spike, count down once per step
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_CH); i++) r_rcnt[i] <= '0;
    end else if (w_proc) begin
      if (w_refr)       r_rcnt[r_ch] <= r_rcnt[r_ch] - RW'(1);
      else if (w_spike) r_rcnt[r_ch] <= RW'(REFRAC_STEPS);
    end
  end
`else
  assign w_refr = 1'b0;
`endif

  // Membrane and threshold update for the channel selected by r_ch
  always_comb begin
    w_v       = r_v[r_ch];
    w_i       = r_cur[r_ch];
    w_th      = r_th[r_ch];
    w_v_ext   = EW'(w_v);
    w_diff    = w_v_ext - VT_E;
    w_exp     = (w_v_ext > VT_E) ? ((w_diff * w_diff) >> EXP_SHIFT) : '0;
    w_sum     = w_v_ext + EW'(w_i) + w_exp - (w_v_ext >> LEAK_SHIFT);
    w_sum_sat = (w_sum > SAT) ? SAT : w_sum;
    w_spike   = !w_refr && (w_sum_sat >= EW'(w_th));
    w_v_new   = (w_spike || w_refr) ? '0 : WIDTH'(w_sum_sat);
    w_th_up   = EW'(w_th) + EW'(w_th >> ADAPT_INC_SHIFT);
    w_th_dn   = EW'(w_th) - EW'(w_th >> ADAPT_DEC_SHIFT);
    if (w_spike) w_th_new = (w_th_up > TMAX_E) ? WIDTH'(TH_MAX) : WIDTH'(w_th_up);
    else         w_th_new = (w_th_dn < TMIN_E) ? WIDTH'(TH_MIN) : WIDTH'(w_th_dn);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        r_v[i]   <= '0;
        r_th[i]  <= WIDTH'(TH_INIT);
        r_cur[i] <= '0;
      end
      r_ch     <= '0;
      r_adapt  <= 1'b0;
      r_shadow <= '0;
      r_spikes <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= w_publish;
      if (w_accept) begin
        for (int i = 0; i < int'(N_CH); i++) r_cur[i] <= current[i*WIDTH +: WIDTH];
        r_adapt <= adapt_en;
        r_ch    <= '0;
        r_busy  <= 1'b1;
      end
      if (w_proc) begin
        r_v[r_ch]      <= w_v_new;
        r_shadow[r_ch] <= w_spike;
        if (r_adapt) r_th[r_ch] <= w_th_new;
        r_ch <= CH_W'(r_ch + CH_W'(1));
      end
      if (w_publish) begin
        r_spikes <= r_shadow;
        r_busy   <= 1'b0;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign spikes = r_spikes;

  // Debug read port; out-of-range selects read as zero
  always_comb begin
    rd_state  = '0;
    rd_thresh = '0;
    if (32'(rd_ch) < N_CH) begin
      rd_state  = r_v[rd_ch];
      rd_thresh = r_th[rd_ch];
    end
  end

endmodule

// File: tb/tb_eif_neuron_array.sv
// Directed bench for eif_neuron_array; expected values hand-derived from the neuron equations.
module tb_eif_neuron_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic        adapt_en;
  logic [31:0] current;
  logic        busy;
  logic        done;
  logic [3:0]  spikes;
  logic [1:0]  rd_ch;
  logic [7:0]  rd_state;
  logic [7:0]  rd_thresh;

  int n_run  = 0;
  int n_fail = 0;

  eif_neuron_array dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .adapt_en  (adapt_en),
    .current   (current),
    .busy      (busy),
    .done      (done),
    .spikes    (spikes),
    .rd_ch     (rd_ch),
    .rd_state  (rd_state),
    .rd_thresh (rd_thresh)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rd(input int ch, output logic [31:0] v, output logic [31:0] th);
    rd_ch = 2'(ch);
    #1;
    v  = 32'(rd_state);
    th = 32'(rd_thresh);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one step from idle and require done exactly 5 edges after acceptance
  task automatic do_step();
    int lat;
    lat  = -1;
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("done_latency", 32'(lat), 32'd5);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] th;
    int          ndone;
    logic [5:0]  pat;
    int          exp_v [3];

    exp_v = '{30, 59, 86};
    rst = 1'b1; step = 1'b0; adapt_en = 1'b0; current = '0; rd_ch = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("t1_spikes", 32'(spikes), 32'd0);
    check("t1_done",   32'(done),   32'd0);
    check("t1_busy",   32'(busy),   32'd0);
    for (int c = 0; c < 4; c++) begin
      rd(c, v, th);
      check($sformatf("t1_th%0d", c), th, 32'd100);
      check($sformatf("t1_v%0d", c),  v,  32'd0);
    end

    // Integration on ch0 with I=30, spike on step 4
    current = 32'h0000_001E;
    for (int s = 0; s < 3; s++) begin
      do_step();
      rd(0, v, th);
      check($sformatf("t2_v0_step%0d", s + 1), v, 32'(exp_v[s]));
      check($sformatf("t2_spk_step%0d", s + 1), 32'(spikes), 32'd0);
    end
    do_step();
    check("t2_spk_step4", 32'(spikes), 32'b0001);
    rd(0, v, th);
    check("t2_v0_step4", v, 32'd0);
    check("t2_th0_noadapt", th, 32'd100);

    // Threshold adaptation: ch1 spikes, idle channels decay
    do_reset();
    adapt_en = 1'b1;
    current  = 32'h0000_FF00;
    do_step();
    check("t3_spk", 32'(spikes), 32'b0010);
    rd(1, v, th);
    check("t3_th1", th, 32'd112);
    rd(2, v, th);
    check("t3_th2", th, 32'd97);
    for (int s = 0; s < 79; s++) do_step();
    rd(2, v, th);
    check("t3_th2_floor", th, 32'd32);
    rd(0, v, th);
    check("t3_th0_floor", th, 32'd32);
`ifndef REFRACTORY_EN
    rd(1, v, th);
    check("t3_th1_ceil", th, 32'd220);

    // Saturation: v=99, th=220, I=255
    adapt_en = 1'b0;
    current  = 32'h0000_6300;
    do_step();
    check("t6_spk_pre", 32'(spikes), 32'd0);
    rd(1, v, th);
    check("t6_v1_pre", v, 32'd99);
    check("t6_th1_pre", th, 32'd220);
    current = 32'h0000_FF00;
    do_step();
    check("t6_spk_sat", 32'(spikes), 32'b0010);
    rd(1, v, th);
    check("t6_v1_sat", v, 32'd0);
    check("t6_th1_sat", th, 32'd220);
`endif

    // Step while busy is ignored
    do_reset();
    adapt_en = 1'b0;
    current  = 32'h0000_001E;
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    @(negedge clk);
    check("t4_busy_run", 32'(busy), 32'd1);
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    check("t4_single_done", 32'(ndone), 32'd1);
    @(negedge clk);
    rd(0, v, th);
    check("t4_v0_one_step", v, 32'd30);

    // Reset mid-sweep aborts without done
    adapt_en = 1'b1;
    current  = 32'hFFFF_FFFF;
    @(negedge clk);
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    check("t4_rst_no_done", 32'(ndone), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      rd(c, v, th);
      check($sformatf("t4_rst_v%0d", c),  v,  32'd0);
      check($sformatf("t4_rst_th%0d", c), th, 32'd100);
    end

    // Spike train on ch0 with I=255
    @(negedge clk);
    adapt_en = 1'b0;
    current  = 32'h0000_00FF;
    pat = '0;
    for (int s = 0; s < 6; s++) begin
      do_step();
      pat[s] = spikes[0];
    end
`ifdef REFRACTORY_EN
    check("t5_pattern", 32'(pat), 32'b001001);
`else
    check("t5_pattern", 32'(pat), 32'b111111);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
